// File: rtl/alu_result_stage.sv
// alu_result_stage
//   Execute-to-memory pipeline stage behind the 64-bit carry ALU. It resolves
//   RISC-V conditional branches from the ALU flags when a bundle is captured,
//   and holds bundles in a 2-entry skid buffer (a main register plus a skid
//   register) so that memory-stage backpressure never drops a result.
//
// Optional feature: define ALU_STAGE_STATS_EN to add the stat_taken and
// stat_stall counter ports.
//
// Ports
//   clk, rst_n            rising-edge clock, asynchronous active-low reset
//   in_valid / in_ready   upstream handshake (in_ready depends on state only)
//   in_result             ALU result
//   in_zero/negative/carry ALU flags (carry = 1 means A >= B unsigned for SUB)
//   in_rd, in_reg_write   destination register and writeback enable
//   in_branch, in_funct3  conditional-branch flag and condition code
//   flush                 synchronous kill of all held entries
//   out_valid / out_ready downstream handshake
//   out_result, out_rd, out_reg_write, out_branch_taken, out_illegal
//                         contents of the main register
//   stat_taken, stat_stall (ALU_STAGE_STATS_EN only) 32-bit wrapping counters
//
// State | meaning
// EMPTY | no entry held
// ONE   | main register holds the oldest entry, skid register unused
// FULL  | main holds the oldest entry, skid holds the next one

module alu_result_stage #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_result,
  input  logic             in_zero,
  input  logic             in_negative,
  input  logic             in_carry,
  input  logic [4:0]       in_rd,
  input  logic             in_reg_write,
  input  logic             in_branch,
  input  logic [2:0]       in_funct3,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic [4:0]       out_rd,
  output logic             out_reg_write,
  output logic             out_branch_taken,
  output logic             out_illegal
`ifdef ALU_STAGE_STATS_EN
  ,
  output logic [31:0]      stat_taken,
  output logic [31:0]      stat_stall
`endif
);

  typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

  state_t state, state_next;

  logic             cap_taken, cap_illegal, cap_reg_write;
  logic             accept;
  logic             load_main_in, load_main_skid, load_skid;

  logic [WIDTH-1:0] skid_result;
  logic [4:0]       skid_rd;
  logic             skid_reg_write, skid_taken, skid_illegal;

  always_comb begin
    cap_taken   = 1'b0;
    cap_illegal = 1'b0;
    if (in_branch) begin
      case (in_funct3)
        3'b000:  cap_taken = in_zero;
        3'b001:  cap_taken = ~in_zero;
        3'b100:  cap_taken = in_negative;
        3'b101:  cap_taken = ~in_negative;
        3'b110:  cap_taken = ~in_carry;
        3'b111:  cap_taken = in_carry;
        default: cap_illegal = 1'b1;
      endcase
    end
  end

  // An illegal branch must never write back.
  assign cap_reg_write = in_reg_write & ~cap_illegal;

  assign in_ready  = (state != FULL);
  assign out_valid = (state != EMPTY);
  assign accept    = in_valid & in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= EMPTY;
    else        state <= state_next;
  end

  always_comb begin
    state_next     = state;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    if (flush) begin
      state_next = EMPTY;
    end else begin
      case (state)
        EMPTY: begin
          if (accept) begin
            load_main_in = 1'b1;
            state_next   = ONE;
          end
        end
        ONE: begin
          if (accept && !out_ready) begin
            load_skid  = 1'b1;
            state_next = FULL;
          end else if (accept && out_ready) begin
            load_main_in = 1'b1;
          end else if (out_ready) begin
            state_next = EMPTY;
          end
        end
        FULL: begin
          if (out_ready) begin
            load_main_skid = 1'b1;
            state_next     = ONE;
          end
        end
        default: state_next = EMPTY;
      endcase
    end
  end

  // The main register drives the outputs directly; it keeps its last value
  // while empty or flushed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_result       <= '0;
      out_rd           <= '0;
      out_reg_write    <= 1'b0;
      out_branch_taken <= 1'b0;
      out_illegal      <= 1'b0;
    end else if (load_main_in) begin
      out_result       <= in_result;
      out_rd           <= in_rd;
      out_reg_write    <= cap_reg_write;
      out_branch_taken <= cap_taken;
      out_illegal      <= cap_illegal;
    end else if (load_main_skid) begin
      out_result       <= skid_result;
      out_rd           <= skid_rd;
      out_reg_write    <= skid_reg_write;
      out_branch_taken <= skid_taken;
      out_illegal      <= skid_illegal;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      skid_result    <= '0;
      skid_rd        <= '0;
      skid_reg_write <= 1'b0;
      skid_taken     <= 1'b0;
      skid_illegal   <= 1'b0;
    end else if (load_skid) begin
      skid_result    <= in_result;
      skid_rd        <= in_rd;
      skid_reg_write <= cap_reg_write;
      skid_taken     <= cap_taken;
      skid_illegal   <= cap_illegal;
    end
  end

`ifdef ALU_STAGE_STATS_EN
  // Counters survive flush; only reset clears them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_taken <= '0;
      stat_stall <= '0;
    end else begin
      if (out_valid && out_ready && out_branch_taken) stat_taken <= stat_taken + 32'd1;
      if (out_valid && !out_ready)                    stat_stall <= stat_stall + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_alu_result_stage.sv
module tb_alu_result_stage;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_result;
  logic        in_zero, in_negative, in_carry;
  logic [4:0]  in_rd;
  logic        in_reg_write;
  logic        in_branch;
  logic [2:0]  in_funct3;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_result;
  logic [4:0]  out_rd;
  logic        out_reg_write;
  logic        out_branch_taken;
  logic        out_illegal;
`ifdef ALU_STAGE_STATS_EN
  logic [31:0] stat_taken;
  logic [31:0] stat_stall;
`endif

  int n_cmp  = 0;
  int n_fail = 0;

  alu_result_stage #(.WIDTH(64)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .in_valid         (in_valid),
    .in_ready         (in_ready),
    .in_result        (in_result),
    .in_zero          (in_zero),
    .in_negative      (in_negative),
    .in_carry         (in_carry),
    .in_rd            (in_rd),
    .in_reg_write     (in_reg_write),
    .in_branch        (in_branch),
    .in_funct3        (in_funct3),
    .flush            (flush),
    .out_valid        (out_valid),
    .out_ready        (out_ready),
    .out_result       (out_result),
    .out_rd           (out_rd),
    .out_reg_write    (out_reg_write),
    .out_branch_taken (out_branch_taken),
    .out_illegal      (out_illegal)
`ifdef ALU_STAGE_STATS_EN
    ,
    .stat_taken       (stat_taken),
    .stat_stall       (stat_stall)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic drive_idle();
    in_valid     = 1'b0;
    in_result    = '0;
    in_zero      = 1'b0;
    in_negative  = 1'b0;
    in_carry     = 1'b0;
    in_rd        = '0;
    in_reg_write = 1'b0;
    in_branch    = 1'b0;
    in_funct3    = '0;
    flush        = 1'b0;
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    out_ready = 1'b0;
    drive_idle();
    #2;
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %0b want 0", out_valid); end
    n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %0b want 1", in_ready); end
    n_cmp++; if (out_result !== 64'd0) begin n_fail++; $display("FAIL reset_out_result got %h want 0", out_result); end
    n_cmp++; if (out_rd !== 5'd0) begin n_fail++; $display("FAIL reset_out_rd got %0d want 0", out_rd); end
    n_cmp++; if (out_reg_write !== 1'b0) begin n_fail++; $display("FAIL reset_out_reg_write got %0b want 0", out_reg_write); end
    n_cmp++; if (out_branch_taken !== 1'b0) begin n_fail++; $display("FAIL reset_out_taken got %0b want 0", out_branch_taken); end
    n_cmp++; if (out_illegal !== 1'b0) begin n_fail++; $display("FAIL reset_out_illegal got %0b want 0", out_illegal); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_passthrough();
    out_ready    = 1'b1;
    in_valid     = 1'b1;
    in_result    = 64'h19;
    in_rd        = 5'd5;
    in_reg_write = 1'b1;
    @(negedge clk);
    drive_idle();
    n_cmp++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL pass_valid got %0b want 1", out_valid); end
    n_cmp++; if (out_result !== 64'h19) begin n_fail++; $display("FAIL pass_result got %h want 19", out_result); end
    n_cmp++; if (out_rd !== 5'd5) begin n_fail++; $display("FAIL pass_rd got %0d want 5", out_rd); end
    n_cmp++; if (out_reg_write !== 1'b1) begin n_fail++; $display("FAIL pass_reg_write got %0b want 1", out_reg_write); end
    n_cmp++; if (out_branch_taken !== 1'b0 || out_illegal !== 1'b0) begin
      n_fail++; $display("FAIL pass_branch got taken=%0b illegal=%0b want 0/0", out_branch_taken, out_illegal);
    end
    @(negedge clk);
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL pass_drain got %0b want 0", out_valid); end
  endtask

  task automatic test_branch_table();
    logic [2:0] f3_list [6];
    logic [2:0] f3;
    logic       z, n, c, exp_taken;
    f3_list = '{3'b000, 3'b001, 3'b100, 3'b101, 3'b110, 3'b111};
    out_ready = 1'b1;
    for (int fi = 0; fi < 6; fi++) begin
      for (int k = 0; k < 8; k++) begin
        f3 = f3_list[fi];
        z = k[2]; n = k[1]; c = k[0];
        case (f3)
          3'b000:  exp_taken = z;
          3'b001:  exp_taken = !z;
          3'b100:  exp_taken = n;
          3'b101:  exp_taken = !n;
          3'b110:  exp_taken = !c;
          default: exp_taken = c;
        endcase
        in_valid = 1'b1; in_branch = 1'b1; in_funct3 = f3; in_reg_write = 1'b1;
        in_zero = z; in_negative = n; in_carry = c;
        in_result = 64'(fi * 8 + k); in_rd = 5'(k);
        @(negedge clk);
        n_cmp++; if (out_valid !== 1'b1 || out_branch_taken !== exp_taken || out_illegal !== 1'b0 || out_reg_write !== 1'b1) begin
          n_fail++; $display("FAIL branch f3=%b znc=%b%b%b got v=%0b taken=%0b ill=%0b rw=%0b want v=1 taken=%0b ill=0 rw=1",
                             f3, z, n, c, out_valid, out_branch_taken, out_illegal, out_reg_write, exp_taken);
        end
      end
    end
    for (int k = 0; k < 2; k++) begin
      in_valid = 1'b1; in_branch = 1'b1; in_funct3 = (k == 0) ? 3'b010 : 3'b011;
      in_reg_write = 1'b1; in_zero = 1'b1; in_negative = 1'b1; in_carry = 1'b1;
      @(negedge clk);
      n_cmp++; if (out_branch_taken !== 1'b0 || out_illegal !== 1'b1 || out_reg_write !== 1'b0) begin
        n_fail++; $display("FAIL branch_illegal k=%0d got taken=%0b ill=%0b rw=%0b want 0/1/0", k, out_branch_taken, out_illegal, out_reg_write);
      end
    end
    in_branch = 1'b0; in_funct3 = 3'b010;
    @(negedge clk);
    n_cmp++; if (out_branch_taken !== 1'b0 || out_illegal !== 1'b0 || out_reg_write !== 1'b1) begin
      n_fail++; $display("FAIL nonbranch_funct3 got taken=%0b ill=%0b rw=%0b want 0/0/1", out_branch_taken, out_illegal, out_reg_write);
    end
    drive_idle();
    @(negedge clk);
  endtask

  task automatic test_backpressure();
    int sent = 0;
    int got  = 0;
    int cyc  = 0;
    while (got < 4 && cyc < 30) begin
      out_ready = (cyc == 0 || cyc >= 6);
      in_valid  = (sent < 4);
      in_result = 64'(sent + 1);
      in_rd     = 5'(sent + 1);
      #1;
      if (cyc == 2) begin
        n_cmp++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready_full got %0b want 0", in_ready); end
      end
      if (cyc == 5) begin
        n_cmp++; if (sent !== 2) begin n_fail++; $display("FAIL bp_capacity accepted %0d want 2", sent); end
        n_cmp++; if (out_result !== 64'd1) begin n_fail++; $display("FAIL bp_hold got %h want 1", out_result); end
      end
      if (out_valid && out_ready) begin
        n_cmp++; if (out_result !== 64'(got + 1)) begin
          n_fail++; $display("FAIL bp_order got %h want %h", out_result, got + 1);
        end
        got++;
      end
      if (in_valid && in_ready) sent++;
      @(negedge clk);
      cyc++;
    end
    drive_idle();
    n_cmp++; if (got !== 4) begin n_fail++; $display("FAIL bp_count got %0d want 4", got); end
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_no_dup got out_valid %0b want 0", out_valid); end
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    in_valid = 1'b1; in_result = 64'hA;
    @(negedge clk);
    in_result = 64'hB;
    @(negedge clk);
    n_cmp++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL flush_prefull got in_ready %0b want 0", in_ready); end
    flush = 1'b1; in_result = 64'hC;
    @(negedge clk);
    drive_idle();
    n_cmp++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++; $display("FAIL flush_full got v=%0b rdy=%0b want 0/1", out_valid, in_ready);
    end
    // flush in ONE with an acceptable incoming bundle: it is dropped too
    in_valid = 1'b1; in_result = 64'hD;
    @(negedge clk);
    flush = 1'b1; in_result = 64'hE;
    @(negedge clk);
    drive_idle();
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_one_drop got v=%0b want 0", out_valid); end
    out_ready = 1'b1;
    in_valid = 1'b1; in_result = 64'hF;
    @(negedge clk);
    drive_idle();
    n_cmp++; if (out_valid !== 1'b1 || out_result !== 64'hF) begin
      n_fail++; $display("FAIL flush_after got v=%0b res=%h want 1/f", out_valid, out_result);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_midstream();
    out_ready = 1'b0;
    in_valid = 1'b1; in_result = 64'h55;
    @(negedge clk);
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    n_cmp++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++; $display("FAIL rst_mid got v=%0b rdy=%0b want 0/1", out_valid, in_ready);
    end
    n_cmp++; if (out_result !== 64'd0) begin n_fail++; $display("FAIL rst_mid_result got %h want 0", out_result); end
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    in_valid = 1'b1; in_result = 64'hFFFF_FFFF_FFFF_FFFF; in_rd = 5'd31; in_reg_write = 1'b1;
    @(negedge clk);
    drive_idle();
    n_cmp++; if (out_valid !== 1'b1 || out_result !== 64'hFFFF_FFFF_FFFF_FFFF || out_rd !== 5'd31) begin
      n_fail++; $display("FAIL rst_after got v=%0b res=%h rd=%0d want 1/ffffffffffffffff/31", out_valid, out_result, out_rd);
    end
    @(negedge clk);
  endtask

`ifdef ALU_STAGE_STATS_EN
  task automatic test_stats();
    rst_n = 1'b0;
    #1;
    n_cmp++; if (stat_taken !== 32'd0 || stat_stall !== 32'd0) begin
      n_fail++; $display("FAIL stats_reset got %0d/%0d want 0/0", stat_taken, stat_stall);
    end
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    in_valid = 1'b1; in_branch = 1'b1; in_funct3 = 3'b000; in_zero = 1'b1;
    repeat (3) @(negedge clk);
    drive_idle();
    @(negedge clk);
    in_valid = 1'b1;
    @(negedge clk);
    drive_idle();
    out_ready = 1'b0;
    repeat (4) @(negedge clk);
    out_ready = 1'b1;
    @(negedge clk);
    n_cmp++; if (stat_taken !== 32'd3) begin n_fail++; $display("FAIL stats_taken got %0d want 3", stat_taken); end
    n_cmp++; if (stat_stall !== 32'd4) begin n_fail++; $display("FAIL stats_stall got %0d want 4", stat_stall); end
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    n_cmp++; if (stat_taken !== 32'd3 || stat_stall !== 32'd4) begin
      n_fail++; $display("FAIL stats_flush got %0d/%0d want 3/4", stat_taken, stat_stall);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_passthrough();
    test_branch_table();
    test_backpressure();
    test_flush();
    test_reset_midstream();
`ifdef ALU_STAGE_STATS_EN
    test_stats();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout simulation did not finish within bound");
    $fatal(1, "timeout");
  end

endmodule
